// File: rtl/bus_dma_engine.sv
// Block-copy / block-fill DMA initiator for the 6502 system bus, programmed through an IO register window.
// Optional completion interrupt enabled by defining BUS_DMA_IRQ_EN (CTRL bit 3 gates irq_o).
module bus_dma_engine #(
    parameter int REG_AW    = 4,
    parameter int MAX_LEN_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cs_i,
    input  logic              R_W_n,
    input  logic [REG_AW-1:0] addr_i,
    input  logic [7:0]        data_i,
    output logic [7:0]        data_o,
    output logic              bus_req_o,
    input  logic              bus_gnt_i,
    output logic [15:0]       m_addr_o,
    output logic              m_rw_n_o,
    output logic [7:0]        m_data_o,
    input  logic [7:0]        m_data_i,
    output logic              irq_o
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_RWAIT, S_WR, S_FIN} state_t;

    state_t               state_q, state_d;
    logic [15:0]          src_q, src_d, dst_q, dst_d;
    logic [MAX_LEN_W-1:0] len_q, len_d;
    logic [15:0]          len16;
    logic [7:0]           latch_q, latch_d, fill_q, data_q, rd_mux;
    logic                 fill_mode_q, irq_en_q, done_q, aborted_q, abort_pend_q;
    logic                 cpu_wr, cpu_rd, busy, wr_ctrl, start_req, abort_now, do_write;

    assign cpu_wr    = cs_i & ~R_W_n;
    assign cpu_rd    = cs_i & R_W_n;
    assign busy      = (state_q != S_IDLE);
    assign wr_ctrl   = cpu_wr && (int'(addr_i) == 6);
    assign start_req = wr_ctrl && data_i[0] && !data_i[2];
    // An ABORT written this cycle takes effect at once; otherwise the pending flag carries it.
    assign abort_now = abort_pend_q | (wr_ctrl & data_i[2]);
    assign do_write  = (state_q == S_WR) && bus_gnt_i;
    assign len16     = 16'(len_q);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        latch_d = latch_q;
        if (cpu_wr && !busy) begin
            case (int'(addr_i))
                0: src_d = {src_q[15:8], data_i};
                1: src_d = {data_i, src_q[7:0]};
                2: dst_d = {dst_q[15:8], data_i};
                3: dst_d = {data_i, dst_q[7:0]};
                4: len_d = MAX_LEN_W'({len16[15:8], data_i});
                5: len_d = MAX_LEN_W'({data_i, len16[7:0]});
                default: ;
            endcase
        end
        case (state_q)
            S_IDLE:  if (start_req && len_q != '0) state_d = S_REQ;
            S_REQ: begin
                if (abort_now)      state_d = S_FIN;
                else if (bus_gnt_i) state_d = fill_mode_q ? S_WR : S_RD;
            end
            S_RD: begin
                if (abort_now)      state_d = S_FIN;
                else if (bus_gnt_i) state_d = S_RWAIT;
            end
            S_RWAIT: begin
                latch_d = m_data_i;
                state_d = abort_now ? S_FIN : S_WR;
            end
            S_WR: begin
                if (bus_gnt_i) begin
                    dst_d = dst_q + 16'd1;
                    if (!fill_mode_q) src_d = src_q + 16'd1;
                    len_d = len_q - 1'b1;
                    if (len_q == MAX_LEN_W'(1) || abort_now) state_d = S_FIN;
                    else state_d = fill_mode_q ? S_WR : S_RD;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 8'h00;
        case (int'(addr_i))
            0: rd_mux = src_q[7:0];
            1: rd_mux = src_q[15:8];
            2: rd_mux = dst_q[7:0];
            3: rd_mux = dst_q[15:8];
            4: rd_mux = len16[7:0];
            5: rd_mux = len16[15:8];
            6: rd_mux = {4'b0, irq_en_q, 1'b0, fill_mode_q, 1'b0};
            7: rd_mux = {5'b0, aborted_q, done_q, busy};
            8: rd_mux = fill_q;
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            latch_q      <= '0;
            fill_q       <= '0;
            data_q       <= '0;
            fill_mode_q  <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            latch_q <= latch_d;
            if (cpu_rd) data_q <= rd_mux;
            if (cpu_wr && !busy && int'(addr_i) == 8) fill_q <= data_i;
            if (wr_ctrl && !busy) fill_mode_q <= data_i[1];
            if (wr_ctrl && data_i[2] && busy && state_q != S_FIN) abort_pend_q <= 1'b1;
            // Completion sets flags with priority over a coincident STATUS read clear.
            if (state_q == S_FIN) begin
                done_q       <= 1'b1;
                aborted_q    <= abort_pend_q;
                abort_pend_q <= 1'b0;
            end else if (!busy && start_req && len_q == '0) begin
                done_q <= 1'b1;
            end else if (cpu_rd && int'(addr_i) == 7) begin
                done_q    <= 1'b0;
                aborted_q <= 1'b0;
            end
        end
    end

`ifdef BUS_DMA_IRQ_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)                  irq_en_q <= 1'b0;
        else if (wr_ctrl && !busy)  irq_en_q <= data_i[3];
    end
    assign irq_o = done_q & irq_en_q;
`else
    assign irq_en_q = 1'b0;
    assign irq_o    = 1'b0;
`endif

    assign data_o    = data_q;
    assign bus_req_o = (state_q == S_REQ) || (state_q == S_RD) ||
                       (state_q == S_RWAIT) || (state_q == S_WR);
    assign m_rw_n_o  = ~do_write;
    assign m_addr_o  = (state_q == S_RD) ? src_q : (state_q == S_WR) ? dst_q : 16'h0000;
    assign m_data_o  = (state_q != S_WR) ? 8'h00 : (fill_mode_q ? fill_q : latch_q);

endmodule

// File: tb/tb_bus_dma_engine.sv
// Directed bench for bus_dma_engine: 64 KiB registered-read memory model, write monitor, tagged checks.
module tb_bus_dma_engine;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cs_i = 1'b0;
    logic        R_W_n = 1'b1;
    logic [3:0]  addr_i = '0;
    logic [7:0]  data_i = '0;
    logic [7:0]  data_o;
    logic        bus_req_o;
    logic        bus_gnt_i = 1'b1;
    logic [15:0] m_addr_o;
    logic        m_rw_n_o;
    logic [7:0]  m_data_o;
    logic [7:0]  m_data_i = '0;
    logic        irq_o;

`ifdef BUS_DMA_IRQ_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          wr_cnt = 0;
    int          req_cycles = 0;
    logic        irq_seen = 1'b0;
    logic [15:0] wr_q[$];
    logic [7:0]  mem[0:65535];
    logic [7:0]  rd;
    int          snap;

    bus_dma_engine dut (
        .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .R_W_n(R_W_n), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_o), .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
        .m_addr_o(m_addr_o), .m_rw_n_o(m_rw_n_o), .m_data_o(m_data_o),
        .m_data_i(m_data_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (!m_rw_n_o) mem[m_addr_o] <= m_data_o;
        m_data_i <= mem[m_addr_o];
    end

    always @(negedge clk_i) begin
        if (bus_req_o) req_cycles++;
        if (!m_rw_n_o) begin
            wr_cnt++;
            wr_q.push_back(m_addr_o);
        end
        if (irq_o) irq_seen = 1'b1;
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reg_wr(input int a, input logic [7:0] d);
        @(posedge clk_i); #1;
        cs_i = 1'b1; R_W_n = 1'b0; addr_i = 4'(a); data_i = d;
        @(posedge clk_i); #1;
        cs_i = 1'b0; R_W_n = 1'b1;
    endtask

    task automatic reg_rd(input int a, output logic [7:0] d);
        @(posedge clk_i); #1;
        cs_i = 1'b1; R_W_n = 1'b1; addr_i = 4'(a);
        @(posedge clk_i); #1;
        cs_i = 1'b0;
        d = data_o;
    endtask

    task automatic setup(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
        reg_wr(0, src[7:0]); reg_wr(1, src[15:8]);
        reg_wr(2, dst[7:0]); reg_wr(3, dst[15:8]);
        reg_wr(4, len[7:0]); reg_wr(5, len[15:8]);
        wr_cnt = 0; req_cycles = 0; wr_q.delete();
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk_i); #1;
        while (bus_req_o && k < 400) begin
            @(negedge clk_i); #1;
            k++;
        end
        if (bus_req_o) check("idle_timeout", bus_req_o, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_wr(input int n);
        int k = 0;
        while (wr_cnt < n && k < 200) begin
            @(negedge clk_i); #1;
            k++;
        end
        if (wr_cnt < n) check("wr_wait_timeout", wr_cnt, n);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset state
        check("rst_data_o", data_o, 8'h00);
        check("rst_bus_req", bus_req_o, 1'b0);
        check("rst_m_addr", m_addr_o, 16'h0000);
        check("rst_m_rw_n", m_rw_n_o, 1'b1);
        check("rst_m_data", m_data_o, 8'h00);
        check("rst_irq", irq_o, 1'b0);
        reg_rd(7, rd); check("rst_status", rd, 8'h00);
        reg_wr(9, 8'hFF); reg_rd(9, rd); check("unmapped_rd", rd, 8'h00);

        // Copy 4 bytes $1000 -> $2000
        setup(16'h1000, 16'h2000, 16'd4);
        reg_wr(6, 8'h01);
        reg_wr(0, 8'h77);
        wait_idle();
        check("copy_req_cycles", req_cycles, 13);
        check("copy_wr_cnt", wr_cnt, 4);
        for (int i = 0; i < 4; i++) check("copy_data", mem[16'h2000 + 16'(i)], pat(16'h1000 + 16'(i)));
        reg_rd(7, rd); check("copy_status1", rd, 8'h02);
        reg_rd(7, rd); check("copy_status2", rd, 8'h00);
        reg_rd(0, rd); check("copy_src_final", rd, 8'h04);
        reg_rd(2, rd); check("copy_dst_final", rd, 8'h04);
        reg_rd(4, rd); check("copy_len_final", rd, 8'h00);

        // Fill $A5 across the address wrap
        setup(16'h0000, 16'hFFFE, 16'd3);
        reg_wr(8, 8'hA5);
        reg_wr(6, 8'h03);
        wait_idle();
        check("fill_wr_cnt", wr_q.size(), 3);
        if (wr_q.size() == 3) begin
            check("fill_addr0", wr_q[0], 16'hFFFE);
            check("fill_addr1", wr_q[1], 16'hFFFF);
            check("fill_addr2", wr_q[2], 16'h0000);
        end
        check("fill_mem0", mem[16'hFFFE], 8'hA5);
        check("fill_mem1", mem[16'hFFFF], 8'hA5);
        check("fill_mem2", mem[16'h0000], 8'hA5);
        check("fill_req_cycles", req_cycles, 4);
        reg_rd(2, rd); check("fill_dst_l", rd, 8'h01);
        reg_rd(3, rd); check("fill_dst_h", rd, 8'h00);
        reg_rd(7, rd); check("fill_status", rd, 8'h02);

        // START with LEN=0
        setup(16'h1000, 16'h2000, 16'd0);
        reg_wr(6, 8'h01);
        reg_rd(7, rd); check("len0_status", rd, 8'h02);
        repeat (4) @(posedge clk_i);
        check("len0_no_req", req_cycles, 0);

        // START+ABORT together in IDLE
        setup(16'h1000, 16'h2000, 16'd2);
        reg_wr(6, 8'h05);
        repeat (4) @(posedge clk_i); #1;
        check("startabort_no_req", req_cycles, 0);
        reg_rd(7, rd); check("startabort_status", rd, 8'h00);

        // ABORT after the second write of an 8-byte copy
        setup(16'h1000, 16'h3000, 16'd8);
        reg_wr(6, 8'h01);
        wait_wr(2);
        reg_wr(6, 8'h04);
        wait_idle();
        check("abort_wr_bound", (wr_cnt == 2 || wr_cnt == 3), 1'b1);
        reg_rd(7, rd); check("abort_status", rd, 8'h06);
        reg_rd(4, rd); check("abort_len", rd, 8'(8 - wr_cnt));
        check("abort_mem0", mem[16'h3000], pat(16'h1000));
        check("abort_mem1", mem[16'h3001], pat(16'h1001));

        // Grant dropped for 5 cycles across the second write
        setup(16'h1000, 16'h4000, 16'd3);
        reg_wr(6, 8'h01);
        wait_wr(1);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        bus_gnt_i = 1'b0;
        snap = wr_cnt;
        repeat (5) begin
            @(negedge clk_i); #1;
            check("stall_rw_n", m_rw_n_o, 1'b1);
        end
        check("stall_no_write", wr_cnt, snap);
        @(posedge clk_i); #1;
        bus_gnt_i = 1'b1;
        wait_idle();
        check("stall_wr_cnt", wr_cnt, 3);
        for (int i = 0; i < 3; i++) check("stall_data", mem[16'h4000 + 16'(i)], pat(16'h1000 + 16'(i)));
        reg_rd(7, rd); check("stall_status", rd, 8'h02);

        // Completion interrupt, CTRL=$09
        setup(16'h1000, 16'h5000, 16'd1);
        reg_wr(6, 8'h09);
        wait_idle();
        check("irq_with_done", irq_o, IRQ_EXP);
        reg_rd(6, rd); check("ctrl_readback", rd, {4'b0, IRQ_EXP, 3'b0});
        reg_rd(7, rd); check("irq_status", rd, 8'h02);
        check("irq_cleared", irq_o, 1'b0);
        check("irq_seen", irq_seen, IRQ_EXP);
        check("irq_copy_data", mem[16'h5000], pat(16'h1000));

        // Reset mid-transfer
        setup(16'h1000, 16'h6000, 16'd8);
        reg_wr(6, 8'h01);
        wait_wr(1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("rst_mid_req", bus_req_o, 1'b0);
        check("rst_mid_rw_n", m_rw_n_o, 1'b1);
        rst_i = 1'b0;
        snap = wr_cnt;
        repeat (10) @(posedge clk_i);
        check("rst_mid_no_write", wr_cnt, snap);
        reg_rd(7, rd); check("rst_mid_status", rd, 8'h00);
        reg_rd(4, rd); check("rst_mid_len", rd, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/bus_dma_engine.md
Name: bus_dma_engine

Overview:
- Bus-initiator companion to the address decoder. It performs memory-to-memory block copy and block fill on the 6502 system bus while the CPU is held off.
- CPU programs it through a register window selected by a decoder chip-select in an IO bank at $FE00-$FEFF.
- Once the arbiter grants the bus, it issues its own reads and writes with the same one-cycle registered read latency the decoder presents to the CPU.

Parameters:
- REG_AW, 4: register offset width.
- MAX_LEN_W, 16: transfer-length counter width.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- cs_i  in  1  register window select from address decoder
- R_W_n  in  1  CPU access direction, 1=read 0=write
- addr_i  in  REG_AW  register offset
- data_i  in  8  CPU write data
- data_o  out  8  register read data, registered, valid cycle after cs_i&R_W_n
- bus_req_o  out  1  bus request to arbiter/CPU RDY logic
- bus_gnt_i  in  1  bus granted
- m_addr_o  out  16  master address
- m_rw_n_o  out  1  master direction, 1=read 0=write
- m_data_o  out  8  master write data
- m_data_i  in  8  master read data, valid one cycle after address
- irq_o  out  1  completion interrupt

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk_i, rst_i).
- Register map (write on cs_i & ~R_W_n at posedge):
  - 0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H, 4 LEN_L, 5 LEN_H
  - 6 CTRL: b0 START (self-clearing), b1 FILL mode, b2 ABORT
  - 7 STATUS (read-only): b0 BUSY, b1 DONE, b2 ABORTED
  - 8 FILL value
  - Offsets 9-15: read 0, writes ignored.
- Writes to offsets 0-5 and 8 while BUSY are ignored. CTRL writes while BUSY honour only ABORT.
- Reading STATUS clears DONE and ABORTED. data_o updates next cycle.
- Reset values: data_o=0, bus_req_o=0, m_addr_o=0, m_rw_n_o=1, m_data_o=0, irq_o=0; all registers 0; state IDLE.
- m_rw_n_o is 1 in every state except WR.
- FSM:
  - IDLE: on START with LEN!=0 -> REQ, BUSY=1. START with LEN=0 -> DONE=1, stay IDLE, no bus request.
  - REQ: bus_req_o=1. When bus_gnt_i=1 -> RD (copy mode) or WR (fill mode).
  - RD: m_addr_o=src, m_rw_n_o=1, one cycle -> RWAIT. If bus_gnt_i=0 on entry, hold in RD until it returns.
  - RWAIT: capture m_data_i into data latch -> WR. Always proceeds regardless of grant.
  - WR: m_addr_o=dst, m_rw_n_o=0, m_data_o=latch (copy) or FILL (fill). Holds while bus_gnt_i=0.
    - On write: dst+=1; src+=1 (copy only); len-=1.
    - len reaching 0 -> FIN, else RD/WR.
  - FIN: bus_req_o=0, BUSY=0, DONE=1 -> IDLE.
- Address arithmetic: 16-bit modulo, so $FFFF+1 -> $0000. No carry into other state.
- Throughput: copy 3 cycles/byte, fill 1 cycle/byte, after grant.
- SRC/DST/LEN read back live values during a transfer, and final values after it.
- ABORT while BUSY:
  - Current write, if in WR, completes.
  - Then go to FIN with ABORTED=1, DONE=1.
  - Remaining LEN is retained.
- Simultaneous START+ABORT in IDLE: ABORT wins, no transfer.
- rst_i mid-transfer: immediate return to IDLE, bus_req_o=0, m_rw_n_o=1 next edge; no partial write completes.

Optional Feature:
- BUS_DMA_IRQ_EN defined: irq_o = DONE & CTRL b3 (IRQ enable, writable). Cleared by STATUS read or rst_i.
- Undefined: irq_o tied 0; CTRL b3 reads 0, writes ignored.

Test Plan:
- SRC=$1000, DST=$2000, LEN=4, copy, gnt immediate:
  - $2000-$2003 equal $1000-$1003.
  - bus_req_o high for exactly 13 cycles: REQ 1 + 4x3 accesses, dropping with FIN.
  - STATUS reads $02, then $00.
- Fill FILL=$A5, DST=$FFFE, LEN=3: writes land at $FFFE, $FFFF, $0000; final DST=$0001.
- LEN=0, START: DONE=1 next cycle, bus_req_o never asserts.
- Copy LEN=8, ABORT written after 2nd write:
  - At most one further write, then FIN.
  - STATUS=$06, LEN reads 5 or 6 consistent with completed writes.
- Drop bus_gnt_i for 5 cycles during WR: m_rw_n_o=1 no further writes during stall, write resumes, data correct.
- With BUS_DMA_IRQ_EN, CTRL=$09: irq_o rises with DONE and falls the cycle after STATUS read. Without the macro, irq_o stays 0.
